net_rx_pkt_fifo: RTL and testbench

- Store-and-forward packet FIFO between the MAC/CMAC RX stream and the TCP stack's s_axis_net_rx input, both 512-bit AXI-Stream in the net clock domain.
- The MAC cannot be back-pressured, so the block always accepts input flits.
- A packet that cannot fit completely is dropped as a whole. A packet that fits is released downstream only after its last flit is stored.
- The TCP stack therefore never sees a truncated frame. Drop and forward statistics are exported.

---
 rtl/net_stream_pkg.sv | 22 ++
 rtl/net_sdp_ram.sv | 25 ++
 rtl/net_rx_pkt_fifo.sv | 182 ++++++++++++++++++
 tb/tb_net_rx_pkt_fifo.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_stream_pkg.sv
// Shared types for the 512-bit net-domain AXI-Stream path: flit payload layout
// and the RX packet FIFO write-side state encoding.
package net_stream_pkg;

  localparam int unsigned NET_DATA_WIDTH = 512;
  localparam int unsigned NET_KEEP_WIDTH = NET_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      last;
    logic [NET_KEEP_WIDTH-1:0] keep;
    logic [NET_DATA_WIDTH-1:0] data;
  } flit_t;

  localparam int unsigned FLIT_WIDTH = $bits(flit_t);

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/net_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
// The array carries no reset; rd_data only changes on a read enable.
module net_sdp_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/net_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO: never back-pressures the MAC, drops packets
// that do not fit (or are too long) as a whole, releases only complete packets.
module net_rx_pkt_fifo
  import net_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = NET_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned DEPTH_LOG2    = 9,
  parameter int unsigned MAX_PKT_FLITS = 24,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                  net_clk,
  input  logic                  net_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic [KEEP_WIDTH-1:0] s_axis_keep,
  input  logic                  s_axis_last,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic [KEEP_WIDTH-1:0] m_axis_keep,
  output logic                  m_axis_last,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic [CNT_WIDTH-1:0]  stat_fwd_pkts,
  output logic [CNT_WIDTH-1:0]  stat_drop_pkts,
  output logic [DEPTH_LOG2:0]   stat_fill
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned FC_W  = $clog2(MAX_PKT_FLITS + 2);

  wr_state_e            state_q, state_d;
  logic [PTR_W-1:0]     wr_cur_q, wr_cur_d;
  logic [PTR_W-1:0]     wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]      flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0] fwd_q, fwd_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [PTR_W-1:0]     fill_q, fill_d;
  logic                 rdy_q, rdy_d;
  logic                 mid_valid_q, mid_valid_d;
  logic                 out_valid_q, out_valid_d;
  flit_t                out_q, out_d;

  flit_t            in_flit;
  flit_t            ram_rdata;
  logic             ram_we;
  logic             ram_re;
  logic             accept;
  logic             full;
  logic             out_take;
  logic [PTR_W-1:0] used;

  assign in_flit = '{last: s_axis_last, keep: s_axis_keep, data: s_axis_data};
  assign accept  = s_axis_valid && rdy_q;
  assign used    = wr_cur_q - rd_ptr_q;
  assign full    = (used == PTR_W'(DEPTH));

  net_sdp_ram #(
    .WIDTH  (FLIT_WIDTH),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (net_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_cur_q[DEPTH_LOG2-1:0]),
    .wr_data (in_flit),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data (ram_rdata)
  );

  // Write side: speculative wr_cur, rolled back to wr_commit on a drop.
  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    flit_cnt_d  = flit_cnt_q;
    fwd_d       = fwd_q;
    drop_d      = drop_q;
    ram_we      = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (accept) begin
          flit_cnt_d = FC_W'(1);
          if (!full) begin
            ram_we   = 1'b1;
            wr_cur_d = wr_cur_q + PTR_W'(1);
            if (s_axis_last) begin
              wr_commit_d = wr_cur_q + PTR_W'(1);
              fwd_d       = fwd_q + CNT_WIDTH'(1);
            end else begin
              state_d = WR_WRITE;
            end
          end else begin
            drop_d = drop_q + CNT_WIDTH'(1);
            if (!s_axis_last) state_d = WR_DROP;
          end
        end
      end
      WR_WRITE: begin
        if (accept) begin
          flit_cnt_d = flit_cnt_q + FC_W'(1);
          if (full || (flit_cnt_q >= FC_W'(MAX_PKT_FLITS))) begin
            wr_cur_d = wr_commit_q;
            drop_d   = drop_q + CNT_WIDTH'(1);
            state_d  = s_axis_last ? WR_IDLE : WR_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_cur_d = wr_cur_q + PTR_W'(1);
            if (s_axis_last) begin
              wr_commit_d = wr_cur_q + PTR_W'(1);
              fwd_d       = fwd_q + CNT_WIDTH'(1);
              state_d     = WR_IDLE;
            end
          end
        end
      end
      WR_DROP: begin
        if (accept && s_axis_last) state_d = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Read side: RAM read register feeds the output register; reads are issued
  // only while downstream is ready so a stalled sink leaves the buffer untouched.
  always_comb begin
    rdy_d       = 1'b1;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_take    = mid_valid_q && (!out_valid_q || m_axis_ready);
    if (!out_valid_q || m_axis_ready) begin
      out_valid_d = mid_valid_q;
      if (mid_valid_q) out_d = ram_rdata;
    end
    ram_re      = (rd_ptr_q != wr_commit_q) && m_axis_ready && (!mid_valid_q || out_take);
    mid_valid_d = ram_re || (mid_valid_q && !out_take);
    rd_ptr_d    = rd_ptr_q + PTR_W'(ram_re);
    fill_d      = wr_commit_d - rd_ptr_d;
  end

  always_ff @(posedge net_clk or negedge net_aresetn) begin
    if (!net_aresetn) begin
      state_q     <= WR_IDLE;
      wr_cur_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      flit_cnt_q  <= '0;
      fwd_q       <= '0;
      drop_q      <= '0;
      fill_q      <= '0;
      rdy_q       <= 1'b0;
      mid_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_cur_q    <= wr_cur_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      flit_cnt_q  <= flit_cnt_d;
      fwd_q       <= fwd_d;
      drop_q      <= drop_d;
      fill_q      <= fill_d;
      rdy_q       <= rdy_d;
      mid_valid_q <= mid_valid_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign s_axis_ready   = rdy_q;
  assign m_axis_valid   = out_valid_q;
  assign m_axis_data    = out_q.data;
  assign m_axis_keep    = out_q.keep;
  assign m_axis_last    = out_q.last;
  assign stat_fwd_pkts  = fwd_q;
  assign stat_drop_pkts = drop_q;
  assign stat_fill      = fill_q;

endmodule

// File: tb/tb_net_rx_pkt_fifo.sv
// Randomised bench for net_rx_pkt_fifo against a packet-level reference model:
// whole packets are either queued for output or counted as dropped.
module tb_net_rx_pkt_fifo;
  import net_stream_pkg::*;

  localparam int unsigned DW    = 512;
  localparam int unsigned KW    = 64;
  localparam int unsigned DL2   = 9;
  localparam int unsigned MAXF  = 24;
  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam int unsigned CHK_W = 640;

  logic          net_clk      = 1'b0;
  logic          net_aresetn  = 1'b0;
  logic [DW-1:0] s_axis_data  = '0;
  logic [KW-1:0] s_axis_keep  = '0;
  logic          s_axis_last  = 1'b0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic [KW-1:0] m_axis_keep;
  logic          m_axis_last;
  logic          m_axis_valid;
  logic          m_axis_ready = 1'b0;
  logic [CW-1:0] stat_fwd_pkts;
  logic [CW-1:0] stat_drop_pkts;
  logic [DL2:0]  stat_fill;

  net_rx_pkt_fifo #(
    .DATA_WIDTH    (DW),
    .KEEP_WIDTH    (KW),
    .DEPTH_LOG2    (DL2),
    .MAX_PKT_FLITS (MAXF),
    .CNT_WIDTH     (CW)
  ) dut (
    .net_clk        (net_clk),
    .net_aresetn    (net_aresetn),
    .s_axis_data    (s_axis_data),
    .s_axis_keep    (s_axis_keep),
    .s_axis_last    (s_axis_last),
    .s_axis_valid   (s_axis_valid),
    .s_axis_ready   (s_axis_ready),
    .m_axis_data    (m_axis_data),
    .m_axis_keep    (m_axis_keep),
    .m_axis_last    (m_axis_last),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .stat_fwd_pkts  (stat_fwd_pkts),
    .stat_drop_pkts (stat_drop_pkts),
    .stat_fill      (stat_fill)
  );

  always #2 net_clk = ~net_clk;

  int    n_checks = 0;
  int    n_errors = 0;
  flit_t exp_q[$];
  int    exp_fwd  = 0;
  int    exp_drop = 0;
  int    beat_cnt = 0;
  int    last_cnt = 0;
  int    run_len  = 0;
  int    max_run  = 0;
  int    ready_mode = 0;
  logic  mon_stall = 1'b0;
  flit_t mon_prev;
  flit_t mon_cur;

  assign mon_cur = {m_axis_last, m_axis_keep, m_axis_data};

  task automatic chk(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready pattern: 0 low, 1 high, 2 toggling, 3 random ~75%.
  always @(posedge net_clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_ready = 1'b0;
      1:       m_axis_ready = 1'b1;
      2:       m_axis_ready = !m_axis_ready;
      default: m_axis_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: every transfer must be the next expected flit; stalled outputs hold.
  always @(negedge net_clk) begin
    if (net_aresetn) begin
      if (mon_stall) begin
        chk("hold_valid", CHK_W'(m_axis_valid), CHK_W'(1'b1));
        chk("hold_flit", CHK_W'(mon_cur), CHK_W'(mon_prev));
      end
      if (m_axis_valid && m_axis_ready) begin
        beat_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (m_axis_last) last_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", CHK_W'(m_axis_valid), CHK_W'(1'b0));
        end else begin
          flit_t e;
          e = exp_q.pop_front();
          chk("out_flit", CHK_W'(mon_cur), CHK_W'(e));
        end
      end else begin
        run_len = 0;
      end
      mon_stall = m_axis_valid && !m_axis_ready;
      mon_prev  = mon_cur;
    end else begin
      mon_stall = 1'b0;
      run_len   = 0;
    end
  end

  task automatic step();
    @(posedge net_clk);
    #1;
  endtask

  task automatic rand_flit(input logic last, input logic [KW-1:0] keep, output flit_t f);
    for (int w = 0; w < DW / 32; w++) f.data[w*32 +: 32] = $urandom();
    f.keep = keep;
    f.last = last;
  endtask

  task automatic drive(input flit_t f);
    s_axis_valid = 1'b1;
    s_axis_data  = f.data;
    s_axis_keep  = f.keep;
    s_axis_last  = f.last;
  endtask

  // Sends one packet; the model queues it only if it is short enough and fits.
  task automatic send_pkt(input int len, input int gap_max, input logic [KW-1:0] last_keep);
    flit_t pkt[$];
    flit_t f;
    for (int i = 0; i < len; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        s_axis_valid = 1'b0;
        step();
      end
      rand_flit(i == len - 1, (i == len - 1) ? last_keep : '1, f);
      pkt.push_back(f);
      drive(f);
      step();
    end
    s_axis_valid = 1'b0;
    if (len <= int'(MAXF) && len <= int'(DEPTH) - exp_q.size()) begin
      foreach (pkt[k]) exp_q.push_back(pkt[k]);
      exp_fwd++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic wait_q(input int limit);
    int t = 0;
    while (exp_q.size() > limit && t < 3000) begin
      step();
      t++;
    end
    chk("queue_wait", CHK_W'(exp_q.size() > limit), CHK_W'(1'b0));
  endtask

  task automatic drain();
    ready_mode = 1;
    wait_q(0);
    repeat (4) step();
  endtask

  task automatic chk_stats(input string tag, input int fill);
    chk({tag, "_fwd"}, CHK_W'(stat_fwd_pkts), CHK_W'(exp_fwd));
    chk({tag, "_drop"}, CHK_W'(stat_drop_pkts), CHK_W'(exp_drop));
    chk({tag, "_fill"}, CHK_W'(stat_fill), CHK_W'(fill));
  endtask

  task automatic do_reset();
    s_axis_valid = 1'b0;
    net_aresetn  = 1'b0;
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    repeat (2) step();
    net_aresetn = 1'b1;
    step();
  endtask

  initial begin
    flit_t f;
    logic [KW-1:0] lk;

    // Reset values
    repeat (2) step();
    chk("rst_s_ready", CHK_W'(s_axis_ready), CHK_W'(1'b0));
    chk("rst_m_valid", CHK_W'(m_axis_valid), CHK_W'(1'b0));
    chk("rst_m_data", CHK_W'(mon_cur), CHK_W'(0));
    chk_stats("rst", 0);
    net_aresetn = 1'b1;
    step();
    chk("rel_s_ready", CHK_W'(s_axis_ready), CHK_W'(1'b1));

    // Single 2-flit packet, latency of exactly two edges
    ready_mode = 1;
    do_reset();
    send_pkt(2, 0, 64'h0000_0000_0000_FFFF);
    chk("lat_e0", CHK_W'(m_axis_valid), CHK_W'(1'b0));
    step();
    chk("lat_e1", CHK_W'(m_axis_valid), CHK_W'(1'b0));
    step();
    chk("lat_e2", CHK_W'(m_axis_valid), CHK_W'(1'b1));
    drain();
    chk_stats("t1", 0);

    // Fill to 504 with output stalled; a 9-flit packet no longer fits
    ready_mode = 0;
    do_reset();
    for (int p = 0; p < 21; p++) send_pkt(24, 0, '1);
    send_pkt(9, 0, '1);
    repeat (2) step();
    chk_stats("t2", 504);
    chk("t2_valid", CHK_W'(m_axis_valid), CHK_W'(1'b0));
    beat_cnt = 0;
    last_cnt = 0;
    drain();
    chk("t2_beats", CHK_W'(beat_cnt), CHK_W'(504));
    chk("t2_lasts", CHK_W'(last_cnt), CHK_W'(21));
    chk_stats("t2_end", 0);

    // Over-length packet dropped, following 1-flit packet forwarded
    ready_mode = 1;
    do_reset();
    send_pkt(25, 0, '1);
    send_pkt(1, 0, 64'h1);
    drain();
    chk_stats("t3", 0);

    // Back-to-back packets with ready toggling every cycle
    ready_mode = 2;
    do_reset();
    for (int p = 0; p < 5; p++) send_pkt(4, 0, 64'h00FF);
    drain();
    chk_stats("t4", 0);

    // Ready held high: commits overlap final reads, output streams without gaps
    ready_mode = 1;
    do_reset();
    max_run = 0;
    send_pkt(4, 0, '1);
    chk("t6_fill_p1", CHK_W'(stat_fill), CHK_W'(4));
    send_pkt(4, 0, '1);
    chk("t6_fill_p2", CHK_W'(stat_fill), CHK_W'(4));
    send_pkt(4, 0, '0);
    drain();
    chk("t6_run", CHK_W'(max_run), CHK_W'(12));
    chk_stats("t6", 0);

    // Reset during flit 3 of 6 with two packets committed
    ready_mode = 2;
    do_reset();
    send_pkt(2, 0, '1);
    send_pkt(2, 0, '1);
    for (int i = 0; i < 2; i++) begin
      rand_flit(1'b0, '1, f);
      drive(f);
      step();
    end
    rand_flit(1'b0, '1, f);
    drive(f);
    net_aresetn = 1'b0;
    exp_q.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    #1;
    chk("t5_valid", CHK_W'(m_axis_valid), CHK_W'(1'b0));
    chk("t5_s_ready", CHK_W'(s_axis_ready), CHK_W'(1'b0));
    chk_stats("t5_rst", 0);
    repeat (2) step();
    s_axis_valid = 1'b0;
    net_aresetn  = 1'b1;
    step();
    chk("t5_rel_ready", CHK_W'(s_axis_ready), CHK_W'(1'b1));
    send_pkt(3, 0, '1);
    send_pkt(2, 0, 64'hFFFF);
    drain();
    chk_stats("t5", 0);

    // Random packets, gaps, keeps and ready patterns
    do_reset();
    for (int p = 0; p < 40; p++) begin
      ready_mode = int'($urandom_range(1, 3));
      wait_q(150);
      case ($urandom_range(0, 3))
        0:       lk = '1;
        1:       lk = '0;
        2:       lk = 64'hFFFF;
        default: lk = {$urandom(), $urandom()};
      endcase
      send_pkt(int'($urandom_range(1, 28)), 2, lk);
    end
    drain();
    chk_stats("rand", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
